// File: rtl/scs8hd_bist_pkg.sv
// Shared types and the golden a41o function for the a41o BIST sequencer.
package scs8hd_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_e;

    localparam int             VEC_W    = 5;
    localparam logic [VEC_W-1:0] LAST_VEC = 5'd31;

    // vec = {B1,A4,A3,A2,A1}
    function automatic logic a41o_golden(input logic [VEC_W-1:0] vec);
        return (&vec[3:0]) | vec[4];
    endfunction

endpackage

// File: rtl/scs8hd_bist_satcnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module scs8hd_bist_satcnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins, increment stops at the maximum.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/scs8hd_a41o_bist_ctrl.sv
// BIST sequencer: sweeps all 32 a41o input vectors, samples DUT_X after a
// settle window and reports mismatch count, first failing vector and pass.
import scs8hd_bist_pkg::*;

module scs8hd_a41o_bist_ctrl #(
    parameter int SETTLE_CYC = 2,
    parameter int ERR_W      = 6
) (
    input  logic             CLK,
    input  logic             RESETB,
    input  logic             START,
    input  logic             ABORT,
    input  logic             DUT_X,
    output logic             A1,
    output logic             A2,
    output logic             A3,
    output logic             A4,
    output logic             B1,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [4:0]       FAIL_VEC
);

    localparam int               CNT_W      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);

    bist_state_e      state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_seen_q, first_seen_d;
    logic [4:0]       fail_vec_q, fail_vec_d;
    logic [VEC_W-1:0] cell_q, cell_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             launch_s;
    logic             mismatch_s;
    logic             err_inc_s;
    logic             err_zero_next_s;
    logic             active_next_s;

    // Sequencer next-state; ABORT overrides every state.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        first_seen_d = first_seen_q;
        fail_vec_d   = fail_vec_q;
        launch_s     = START && !ABORT && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        mismatch_s   = (state_q == ST_CHECK) && (DUT_X != a41o_golden(vec_q));
        err_inc_s    = mismatch_s && !ABORT;
        if (ABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state_d      = ST_SETTLE;
                        vec_d        = 5'd0;
                        cnt_d        = CNT_RELOAD;
                        first_seen_d = 1'b0;
                        fail_vec_d   = 5'd0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1'b1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch_s && !first_seen_q) begin
                        fail_vec_d   = vec_q;
                        first_seen_d = 1'b1;
                    end else begin
                        fail_vec_d = fail_vec_q;
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d   = vec_q + 5'd1;
                        cnt_d   = CNT_RELOAD;
                        state_d = ST_SETTLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are derived from the next state so they change on the same edge.
    always_comb begin
        active_next_s   = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
        cell_d          = active_next_s ? vec_d : 5'd0;
        busy_d          = active_next_s;
        done_d          = (state_d == ST_DONE);
        err_zero_next_s = launch_s || ((ERR_CNT == '0) && !err_inc_s);
        pass_d          = done_d && err_zero_next_s;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            state_q      <= ST_IDLE;
            vec_q        <= 5'd0;
            cnt_q        <= '0;
            first_seen_q <= 1'b0;
            fail_vec_q   <= 5'd0;
            cell_q       <= 5'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            first_seen_q <= first_seen_d;
            fail_vec_q   <= fail_vec_d;
            cell_q       <= cell_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    scs8hd_bist_satcnt #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (CLK),
        .rst_n (RESETB),
        .clr   (launch_s),
        .inc   (err_inc_s),
        .cnt   (ERR_CNT)
    );

    assign A1       = cell_q[0];
    assign A2       = cell_q[1];
    assign A3       = cell_q[2];
    assign A4       = cell_q[3];
    assign B1       = cell_q[4];
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = pass_q;
    assign FAIL_VEC = fail_vec_q;

endmodule

// File: tb/tb_scs8hd_a41o_bist_ctrl.sv
// Self-checking bench: a behavioural cell (optionally faulted) drives DUT_X;
// sweep results and per-cycle outputs are compared with a vector-level model.
module tb_scs8hd_a41o_bist_ctrl;

    logic        clk    = 1'b0;
    logic        resetb = 1'b0;
    logic        start  = 1'b0;
    logic        abort  = 1'b0;
    logic        dut_x;
    logic        dut_x3;
    logic        a1, a2, a3, a4, b1, busy, done, pass;
    logic [5:0]  err_cnt;
    logic [4:0]  fail_vec;
    logic [4:0]  cell3;
    logic        busy3, done3, pass3;
    logic [2:0]  err3;
    logic [4:0]  fail3;
    logic [4:0]  obs_vec;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cur_mode = 0;
    bit [31:0]   cur_flip = 32'h0;

    always #5 clk = ~clk;

    scs8hd_a41o_bist_ctrl dut (
        .CLK(clk), .RESETB(resetb), .START(start), .ABORT(abort), .DUT_X(dut_x),
        .A1(a1), .A2(a2), .A3(a3), .A4(a4), .B1(b1),
        .BUSY(busy), .DONE(done), .PASS(pass), .ERR_CNT(err_cnt), .FAIL_VEC(fail_vec)
    );

    scs8hd_a41o_bist_ctrl #(.SETTLE_CYC(2), .ERR_W(3)) dut3 (
        .CLK(clk), .RESETB(resetb), .START(start), .ABORT(abort), .DUT_X(dut_x3),
        .A1(cell3[0]), .A2(cell3[1]), .A3(cell3[2]), .A4(cell3[3]), .B1(cell3[4]),
        .BUSY(busy3), .DONE(done3), .PASS(pass3), .ERR_CNT(err3), .FAIL_VEC(fail3)
    );

    function automatic bit ref_x(input int v);
        return ((v % 16) == 15) || (v >= 16);
    endfunction

    // Cell under test: 0 = good cell with optional per-vector flips, 1 = stuck 0, 2 = stuck 1
    function automatic bit cell_out(input int mode, input bit [31:0] flip, input int v);
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        return ref_x(v) ^ flip[v];
    endfunction

    assign obs_vec = {b1, a4, a3, a2, a1};
    assign dut_x   = cell_out(cur_mode, cur_flip, int'(obs_vec));
    assign dut_x3  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Result of checking the first nvec vectors: saturated error count and first failing vector
    task automatic model(input int mode, input bit [31:0] flip, input int nvec, input int maxc,
                         output int ec, output int fv);
        int n;
        bit seen;
        n = 0; seen = 1'b0; fv = 0;
        for (int v = 0; v < nvec; v++) begin
            if (cell_out(mode, flip, v) != ref_x(v)) begin
                n++;
                if (!seen) begin
                    seen = 1'b1;
                    fv = v;
                end
            end
        end
        ec = (n > maxc) ? maxc : n;
    endtask

    // One sweep; k counts edges after the one that samples START
    task automatic sweep(input int mode, input bit [31:0] flip, input int abort_at,
                         input int reset_at, input int restart_at);
        int ec, fv, ec3, fv3, nv;
        cur_mode = mode;
        cur_flip = flip;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k <= 96; k++) begin
            @(posedge clk);
            #1;
            start  = (k == restart_at);
            abort  = (k + 1 == abort_at);
            resetb = !(k + 1 == reset_at);
            if (k == abort_at) begin
                nv = (k - 1) / 3;
                model(mode, flip, nv, 63, ec, fv);
                model(1, 32'h0, nv, 7, ec3, fv3);
                chk("abort_outs", {busy, done, pass, obs_vec}, 32'h0);
                chk("abort_err", err_cnt, ec);
                chk("abort_fvec", fail_vec, fv);
                chk("abort_err3", {err3, fail3}, {3'(ec3), 5'(fv3)});
                break;
            end else if (k == reset_at) begin
                chk("reset_outs", {busy, done, pass, obs_vec, err_cnt, fail_vec}, 32'h0);
                chk("reset_outs3", {busy3, done3, pass3, cell3, err3, fail3}, 32'h0);
                break;
            end else if (k < 96) begin
                chk("run", {busy, done, pass, obs_vec}, {1'b1, 1'b0, 1'b0, 5'(k / 3)});
            end else begin
                model(mode, flip, 32, 63, ec, fv);
                model(1, 32'h0, 32, 7, ec3, fv3);
                chk("done_flags", {busy, done, pass, obs_vec}, {1'b0, 1'b1, (ec == 0), 5'd0});
                chk("done_err", err_cnt, ec);
                chk("done_fvec", fail_vec, fv);
                chk("done3", {busy3, done3, pass3, err3, fail3},
                    {1'b0, 1'b1, 1'b0, 3'(ec3), 5'(fv3)});
            end
        end
        start  = 1'b0;
        abort  = 1'b0;
        resetb = 1'b1;
    endtask

    initial begin
        resetb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {busy, done, pass, obs_vec, err_cnt, fail_vec}, 32'h0);
        chk("reset_state3", {busy3, done3, pass3, cell3, err3, fail3}, 32'h0);
        resetb = 1'b1;

        sweep(0, 32'h0, -1, -1, -1);                  // good cell
        sweep(1, 32'h0, -1, -1, -1);                  // stuck 0: 17 errors, first 0x0F
        sweep(2, 32'h0, -1, -1, -1);                  // stuck 1: 15 errors, first 0x00
        sweep(0, 32'h8000_0000, -1, -1, -1);          // only the last vector wrong
        for (int i = 0; i < 3; i++) begin
            sweep(0, $urandom(), -1, -1, -1);
        end
        sweep(0, $urandom() | 32'h1, 40, -1, -1);     // abort mid-sweep, results kept

        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort", {busy, done, obs_vec}, 32'h0);

        sweep(0, 32'h0, -1, -1, -1);                  // full sweep after abort
        sweep(0, $urandom() | 32'h1, -1, 50, -1);     // reset mid-sweep
        sweep(0, $urandom(), -1, -1, 20);             // START while busy is ignored

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
